coherence_bus_ctrl: RTL
=======================

Name: coherence_bus_ctrl

Overview:
- Downstream neighbour of the per-core write-back dcache and the icache.
- Arbitrates two cores' instruction fetches, data evictions and coherence transactions (cctrans/ccwrite) onto a single-ported RAM.
- Drives snoops (ccwait/ccinv/ccsnoopaddr) into the non-requesting dcache, and forwards dirty snoop writebacks cache-to-cache while also writing them to RAM.
- Two-word blocks; one word per RAM access.

Parameters:
- CPUS, 2, number of cores. Fixed at 2; index 0/1 used throughout.
- WORD_W, 32, data/address width.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  2  per-core instruction read request
- iaddr  in  2x32  per-core instruction address
- iwait  out  2  per-core instruction stall
- iload  out  2x32  per-core instruction data
- dREN  in  2  per-core data read (block fill)
- dWEN  in  2  per-core data write (eviction, flush or snoop writeback)
- daddr  in  2x32  per-core data address
- dstore  in  2x32  per-core write data
- dwait  out  2  per-core data stall
- dload  out  2x32  per-core read data
- cctrans  in  2  cache starting or holding a coherence transaction
- ccwrite  in  2  transaction is for write (requires invalidate)
- ccwait  out  2  cache is being snooped; must enter its snoop state
- ccinv  out  2  snooped cache must invalidate the matching line
- ccsnoopaddr  out  2x32  snoop address
- ramREN  out  1  RAM read
- ramWEN  out  1  RAM write
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ram_ready  in  1  RAM access completes this cycle

Behaviour:
- Reset values:
  - state=IDLE, last_grant=1, so core 0 wins the first tie.
  - dwait=2'b11, iwait=2'b11.
  - ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore all 0; dload, iload 0.
  - Reset mid-transaction aborts to IDLE; no RAM strobe is held over.
- Defaults in every state: dwait=iwait=11, RAM strobes 0.
- Grant in IDLE, highest priority first:
  1. Any cctrans
  2. dWEN without cctrans (plain eviction or flush)
  3. iREN
- Within a class, round-robin: on a tie the core != last_grant wins; last_grant updates on every grant. Requester index r, other index o=~r. Latched at grant, held until DONE.
- IDLE:
  - cctrans[r]: latch addr=daddr[r] and wr=ccwrite[r] -> SNOOP.
  - dWEN[r] only -> EVICT.
  - iREN[r] only -> IFETCH.
  - Nothing pending -> stay IDLE.
- SNOOP (exactly 1 cycle): ccwait[o]=1, ccsnoopaddr[o]=addr, ccinv[o]=wr.
  - dWEN[o]=1 (peer dirty) -> FWD1.
  - Otherwise -> FILL1.
- FWD1/FWD2 (cache-to-cache):
  - Hold ccwait[o]/ccinv[o]/ccsnoopaddr[o].
  - ramWEN=1, ramaddr=daddr[o], ramstore=dstore[o].
  - dload[r]=dstore[o]. dwait[o]=dwait[r]=~ram_ready.
  - Advance on ram_ready: FWD1->FWD2->DONE.
  - Requester's RAM read is suppressed; the peer supplies the data.
- FILL1/FILL2:
  - ccwait[o]=1, ccinv[o]=wr, held through both words so the peer stays parked.
  - ramREN=1, ramaddr=daddr[r], dload[r]=ramload, dwait[r]=~ram_ready.
  - Advance on ram_ready: FILL1->FILL2->DONE.
- EVICT:
  - ramWEN=1, ramaddr=daddr[r], ramstore=dstore[r], dwait[r]=~ram_ready.
  - Stay while dWEN[r]=1 (one word per ram_ready); dWEN[r]=0 -> IDLE.
- IFETCH:
  - ramREN=1, ramaddr=iaddr[r], iload[r]=ramload, iwait[r]=~ram_ready.
  - On ram_ready -> IDLE; request dropped early -> IDLE.
- DONE (1 cycle): all cc outputs 0, then -> IDLE. Guarantees a one-cycle ccwait gap between transactions.
- Simultaneous cases:
  - Both caches raise cctrans: only the grantee is served. The loser is snooped (it sees ccwait) and must drop cctrans; it re-requests after DONE.
  - dREN/dWEN/iREN on a core whose ccwait is high is ignored.
- A core never snoops itself. ccwait is only ever asserted on o.
- Address bits [1:0] pass through unmodified.
- Latency, ram_ready tied 1:
  - Coherent fill = 4 cycles (IDLE, SNOOP, FILL1, FILL2) + DONE.
  - Forward = same count.
  - Ifetch = 2 cycles.

Test Plan:
- Reset with all requests asserted -> outputs at reset values; first posedge after release grants core 0 cctrans over core 1 cctrans.
- Core0 cctrans, ccwrite=0, daddr=0x100; core1 no dWEN in SNOOP; ram_ready=1, ramload=0xAAAA then 0xBBBB -> ccwait[1]=1, ccinv[1]=0, ccsnoopaddr[1]=0x100; dload[0] gets 0xAAAA then 0xBBBB; then DONE -> IDLE.
- Core1 ccwrite=1 addr 0x200; core0 answers with dWEN, dstore=0x11/0x22 at 0x200/0x204 -> ccinv[0]=1; ramWEN=1; ramstore=dload[1]=0x11 then 0x22; ramREN stays 0.
- Core0 iREN held, core1 cctrans arrives same cycle -> core1 granted first; core0 iwait=1 throughout; fetch serviced after DONE.
- Both iREN continuous, ram_ready=1 -> grants alternate 0,1,0,1; each iload matches ramload for its iaddr.
- ram_ready held 0 for 3 cycles in FILL1 -> dwait[r]=1, state and address stable; on ready, advances; nRST pulsed in FILL2 -> IDLE, strobes 0 immediately.

Source files
------------

// File: rtl/coherence_bus_ctrl.sv
// rtl/coherence_bus_ctrl.sv - two-core coherence bus arbiter, snoop driver and single-port RAM sequencer
module coherence_bus_ctrl #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic [CPUS-1:0]             iREN,
    input  logic [CPUS-1:0][WORD_W-1:0] iaddr,
    output logic [CPUS-1:0]             iwait,
    output logic [CPUS-1:0][WORD_W-1:0] iload,
    input  logic [CPUS-1:0]             dREN,
    input  logic [CPUS-1:0]             dWEN,
    input  logic [CPUS-1:0][WORD_W-1:0] daddr,
    input  logic [CPUS-1:0][WORD_W-1:0] dstore,
    output logic [CPUS-1:0]             dwait,
    output logic [CPUS-1:0][WORD_W-1:0] dload,
    input  logic [CPUS-1:0]             cctrans,
    input  logic [CPUS-1:0]             ccwrite,
    output logic [CPUS-1:0]             ccwait,
    output logic [CPUS-1:0]             ccinv,
    output logic [CPUS-1:0][WORD_W-1:0] ccsnoopaddr,
    output logic                        ramREN,
    output logic                        ramWEN,
    output logic [WORD_W-1:0]           ramaddr,
    output logic [WORD_W-1:0]           ramstore,
    input  logic [WORD_W-1:0]           ramload,
    input  logic                        ram_ready
);

    typedef enum logic [3:0] {
        IDLE, SNOOP, FWD1, FWD2, FILL1, FILL2, EVICT, IFETCH, DONE
    } state_t;

    state_t              state, next_state;
    logic                last_grant;
    logic                req;
    logic                peer;
    logic [WORD_W-1:0]   addr_q;
    logic                wr_q;
    logic [CPUS-1:0]     ev_req;
    logic [CPUS-1:0]     cls;
    logic                grant_any;
    logic                grant_idx;
    logic                dren_unused;

    // Block fills arrive as coherence transactions, so dREN carries no extra information.
    assign dren_unused = ^dREN;
    assign peer        = ~req;

    always_comb begin
        ev_req = dWEN & ~cctrans;
        if (|cctrans)
            cls = cctrans;
        else if (|ev_req)
            cls = ev_req;
        else
            cls = iREN;
        grant_any = |cls;
        grant_idx = (&cls) ? ~last_grant : cls[1];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            req        <= 1'b0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && grant_any) begin
                last_grant <= grant_idx;
                req        <= grant_idx;
                addr_q     <= daddr[grant_idx];
                wr_q       <= ccwrite[grant_idx];
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (|cctrans)
                    next_state = SNOOP;
                else if (|ev_req)
                    next_state = EVICT;
                else if (|iREN)
                    next_state = IFETCH;
            end
            SNOOP:  next_state = dWEN[peer] ? FWD1 : FILL1;
            FWD1:   if (ram_ready) next_state = FWD2;
            FWD2:   if (ram_ready) next_state = DONE;
            FILL1:  if (ram_ready) next_state = FILL2;
            FILL2:  if (ram_ready) next_state = DONE;
            EVICT:  if (!dWEN[req]) next_state = IDLE;
            IFETCH: if (ram_ready || !iREN[req]) next_state = IDLE;
            DONE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (state)
            SNOOP: begin
                ccwait[peer]      = 1'b1;
                ccinv[peer]       = wr_q;
                ccsnoopaddr[peer] = addr_q;
            end
            FWD1, FWD2: begin
                ccwait[peer]      = 1'b1;
                ccinv[peer]       = wr_q;
                ccsnoopaddr[peer] = addr_q;
                ramWEN            = 1'b1;
                ramaddr           = daddr[peer];
                ramstore          = dstore[peer];
                dload[req]        = dstore[peer];
                dwait[peer]       = ~ram_ready;
                dwait[req]        = ~ram_ready;
            end
            FILL1, FILL2: begin
                // Peer stays parked in its snoop state until the whole block has landed.
                ccwait[peer]      = 1'b1;
                ccinv[peer]       = wr_q;
                ccsnoopaddr[peer] = addr_q;
                ramREN            = 1'b1;
                ramaddr           = daddr[req];
                dload[req]        = ramload;
                dwait[req]        = ~ram_ready;
            end
            EVICT: begin
                ramWEN     = dWEN[req];
                ramaddr    = daddr[req];
                ramstore   = dstore[req];
                dwait[req] = ~ram_ready;
            end
            IFETCH: begin
                ramREN     = iREN[req];
                ramaddr    = iaddr[req];
                iload[req] = ramload;
                iwait[req] = ~ram_ready;
            end
            default: ;
        endcase
    end

endmodule
